// File: rtl/simd_result_collector_pkg.sv
// Shared constants and types for the SIMD result collector slice.
package simd_pkg;

   localparam int unsigned NUM_PROCC      = 4;
   localparam int unsigned WORDS_PER_VEC  = 2 * NUM_PROCC;
   localparam int unsigned WORD_W_DEFAULT = 32;
   localparam int unsigned IDX_W          = 3;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   // Word order inside a streamed vector: result then extra_result, lane by lane.
   typedef enum logic [IDX_W-1:0] {
      IDX_RES_P0 = 3'd0,
      IDX_EXT_P0 = 3'd1,
      IDX_RES_P1 = 3'd2,
      IDX_EXT_P1 = 3'd3,
      IDX_RES_P2 = 3'd4,
      IDX_EXT_P2 = 3'd5,
      IDX_RES_P3 = 3'd6,
      IDX_EXT_P3 = 3'd7
   } out_idx_e;

   localparam logic [IDX_W-1:0] IDX_FIRST = IDX_RES_P0;
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_EXT_P3;

endpackage

// File: rtl/simd_result_collector_if.sv
// Lane capture inputs, output word stream and status of the result collector.
interface simd_result_collector_if #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned WORD_W = 32
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic              procc_done;
   logic [WORD_W-1:0] res_p0, res_p1, res_p2, res_p3;
   logic [WORD_W-1:0] ext_p0, ext_p1, ext_p2, ext_p3;
   logic [WORD_W-1:0] out_data;
   logic [2:0]        out_index;
   logic              out_valid;
   logic              out_last;
   logic              out_ready;
   logic              full;
   logic [CNT_W-1:0]  count;
   logic              overflow;
   logic              clr_overflow;

   modport master (
      input  procc_done, res_p0, res_p1, res_p2, res_p3,
             ext_p0, ext_p1, ext_p2, ext_p3, out_ready, clr_overflow,
      output out_data, out_index, out_valid, out_last, full, count, overflow
   );

   modport slave (
      output procc_done, res_p0, res_p1, res_p2, res_p3,
             ext_p0, ext_p1, ext_p2, ext_p3, out_ready, clr_overflow,
      input  out_data, out_index, out_valid, out_last, full, count, overflow
   );

endinterface

// File: rtl/simd_result_collector_fifo.sv
// Vector FIFO: DEPTH slots of eight lane words with head/tail pointers and occupancy.
module simd_result_fifo
   import simd_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned WORD_W = WORD_W_DEFAULT
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic                                      push_i,
   input  logic [WORDS_PER_VEC-1:0][WORD_W-1:0]      push_data_i,
   input  logic                                      pop_i,
   output logic [WORDS_PER_VEC-1:0][WORD_W-1:0]      head_vec_c_o,
   output logic [WORDS_PER_VEC-1:0][WORD_W-1:0]      next_vec_c_o,
   output logic [$clog2(DEPTH):0]                    count_o,
   output logic                                      full_o
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WORDS_PER_VEC-1:0][WORD_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] head_q, tail_q;
   logic [PTR_W-1:0] head_d, tail_d, head_nxt;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q, full_d;

   assign head_nxt     = PTR_W'(head_q + 1'b1);
   assign head_vec_c_o = mem_q[head_q];
   assign next_vec_c_o = mem_q[head_nxt];
   assign count_o      = count_q;
   assign full_o       = full_q;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push_i) tail_d = PTR_W'(tail_q + 1'b1);
      if (pop_i)  head_d = head_nxt;
      case ({push_i, pop_i})
         2'b10:   count_d = CNT_W'(count_q + 1'b1);
         2'b01:   count_d = CNT_W'(count_q - 1'b1);
         default: count_d = count_q;
      endcase
      full_d = (count_d == CNT_W'(DEPTH));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         full_q  <= full_d;
      end
   end

   // Payload storage carries no reset; occupancy alone says what is live.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[tail_q] <= push_data_i;
   end

endmodule

// File: rtl/simd_result_collector.sv
// Captures completed lane vectors on procc_done rising and streams them word by word.
module simd_result_collector
   import simd_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned WORD_W = WORD_W_DEFAULT
) (
   input  logic                     clk,
   input  logic                     reset,
   simd_result_collector_if.master  res_if
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [WORDS_PER_VEC-1:0][WORD_W-1:0] cap_vec, head_vec, next_vec;
   logic [CNT_W-1:0]  count;
   logic              full;

   state_e            state_q, state_d;
   logic              done_q;
   logic [IDX_W-1:0]  word_ptr_q, word_ptr_d;
   logic [WORD_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              last_q, last_d;
   logic              overflow_q, overflow_d;

   logic cap, pop, pop_last, push, drop;

   assign cap_vec = {res_if.ext_p3, res_if.res_p3, res_if.ext_p2, res_if.res_p2,
                     res_if.ext_p1, res_if.res_p1, res_if.ext_p0, res_if.res_p0};

   assign cap      = res_if.procc_done & ~done_q;
   assign pop      = valid_q & res_if.out_ready;
   assign pop_last = pop & (word_ptr_q == IDX_LAST);
   // A full buffer still takes a capture when its head slot frees on the same edge.
   assign push     = cap & (~full | pop_last);
   assign drop     = cap & ~push;

   simd_result_fifo #(
      .DEPTH  (DEPTH),
      .WORD_W (WORD_W)
   ) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .push_i       (push),
      .push_data_i  (cap_vec),
      .pop_i        (pop_last),
      .head_vec_c_o (head_vec),
      .next_vec_c_o (next_vec),
      .count_o      (count),
      .full_o       (full)
   );

   // Next output word is chosen from storage or the capture so out_data stays registered.
   always_comb begin
      state_d    = state_q;
      word_ptr_d = word_ptr_q;
      data_d     = data_q;
      overflow_d = overflow_q;
      case (state_q)
         IDLE: begin
            if (push) begin
               state_d    = SEND;
               word_ptr_d = IDX_FIRST;
               data_d     = cap_vec[IDX_FIRST];
            end
         end
         SEND: begin
            if (pop_last) begin
               word_ptr_d = IDX_FIRST;
               if (count > CNT_W'(1)) begin
                  data_d = next_vec[IDX_FIRST];
               end else if (push) begin
                  data_d = cap_vec[IDX_FIRST];
               end else begin
                  state_d = IDLE;
                  data_d  = '0;
               end
            end else if (pop) begin
               word_ptr_d = IDX_W'(word_ptr_q + 1'b1);
               data_d     = head_vec[word_ptr_d];
            end
         end
         default: begin
            state_d    = IDLE;
            word_ptr_d = IDX_FIRST;
            data_d     = '0;
         end
      endcase
      valid_d = (state_d == SEND);
      last_d  = valid_d & (word_ptr_d == IDX_LAST);
      if (res_if.clr_overflow) overflow_d = 1'b0;
      if (drop)                overflow_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         done_q     <= 1'b0;
         word_ptr_q <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         done_q     <= res_if.procc_done;
         word_ptr_q <= word_ptr_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         last_q     <= last_d;
         overflow_q <= overflow_d;
      end
   end

   assign res_if.out_data  = data_q;
   assign res_if.out_index = word_ptr_q;
   assign res_if.out_valid = valid_q;
   assign res_if.out_last  = last_q;
   assign res_if.full      = full;
   assign res_if.count     = count;
   assign res_if.overflow  = overflow_q;

endmodule

// File: tb/tb_simd_result_collector.sv
// Randomized bench for simd_result_collector against a queue-based reference model.
module tb_simd_result_collector;
   localparam int DEPTH = 4;

   typedef logic [7:0][31:0] vec_t;

   logic clk;
   logic reset;
   bit   chk_en;
   int   n_vec;
   int   n_err;

   simd_result_collector_if #(.DEPTH(DEPTH), .WORD_W(32)) bus ();

   simd_result_collector #(.DEPTH(DEPTH), .WORD_W(32)) dut (
      .clk    (clk),
      .reset  (reset),
      .res_if (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: queue of whole vectors, word position in the head, sticky flag.
   vec_t        mq[$];
   int unsigned wp;
   bit          m_ovf;
   bit          m_prev;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mq.delete();
         wp     = 0;
         m_ovf  = 1'b0;
         m_prev = 1'b0;
      end else begin
         bit   pop, last, cap, acc;
         vec_t v;
         pop  = (mq.size() > 0) && bus.out_ready;
         last = pop && (wp == 7);
         cap  = bus.procc_done && !m_prev;
         acc  = cap && ((mq.size() < DEPTH) || last);
         v[0] = bus.res_p0; v[1] = bus.ext_p0;
         v[2] = bus.res_p1; v[3] = bus.ext_p1;
         v[4] = bus.res_p2; v[5] = bus.ext_p2;
         v[6] = bus.res_p3; v[7] = bus.ext_p3;
         if (pop) begin
            if (last) begin
               void'(mq.pop_front());
               wp = 0;
            end else begin
               wp = wp + 1;
            end
         end
         if (acc) mq.push_back(v);
         if (bus.clr_overflow) m_ovf = 1'b0;
         if (cap && !acc)      m_ovf = 1'b1;
         m_prev = bus.procc_done;
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         bit ev;
         ev = mq.size() > 0;
         check("valid", 32'(bus.out_valid), 32'(ev));
         check("count", 32'(bus.count), mq.size());
         check("full", 32'(bus.full), 32'(mq.size() == DEPTH));
         check("overflow", 32'(bus.overflow), 32'(m_ovf));
         if (ev) begin
            check("data", bus.out_data, mq[0][wp]);
            check("index", 32'(bus.out_index), wp);
            check("last", 32'(bus.out_last), 32'(wp == 7));
         end
      end
   end

   task automatic set_lanes(input logic [31:0] base_r, input logic [31:0] base_e);
      bus.res_p0 = base_r;      bus.res_p1 = base_r + 1;
      bus.res_p2 = base_r + 2;  bus.res_p3 = base_r + 3;
      bus.ext_p0 = base_e;      bus.ext_p1 = base_e + 1;
      bus.ext_p2 = base_e + 2;  bus.ext_p3 = base_e + 3;
   endtask

   task automatic rand_lanes();
      bus.res_p0 = $urandom; bus.res_p1 = $urandom;
      bus.res_p2 = $urandom; bus.res_p3 = $urandom;
      bus.ext_p0 = $urandom; bus.ext_p1 = $urandom;
      bus.ext_p2 = $urandom; bus.ext_p3 = $urandom;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_last"}, 32'(bus.out_last), 32'd0);
      check({tag, "_index"}, 32'(bus.out_index), 32'd0);
      check({tag, "_data"}, bus.out_data, 32'd0);
      check({tag, "_full"}, 32'(bus.full), 32'd0);
      check({tag, "_count"}, 32'(bus.count), 32'd0);
      check({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
   endtask

   // One capture pulse: done high for one cycle then low for one cycle.
   task automatic pulse_rand();
      rand_lanes();
      bus.procc_done = 1'b1;
      @(negedge clk);
      bus.procc_done = 1'b0;
      @(negedge clk);
   endtask

   logic [31:0] exp_seq [8];

   initial begin
      n_vec = 0;
      n_err = 0;
      chk_en = 1'b0;
      exp_seq = '{32'h10, 32'h20, 32'h11, 32'h21, 32'h12, 32'h22, 32'h13, 32'h23};
      reset = 1'b0;
      bus.procc_done = 1'b0;
      bus.out_ready = 1'b0;
      bus.clr_overflow = 1'b0;
      set_lanes(32'h0, 32'h0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1 check_reset_outputs("rst");
      chk_en = 1'b1;
      repeat (20) @(negedge clk);
      check_reset_outputs("idle");

      // Single vector with literal expectations
      set_lanes(32'h10, 32'h20);
      bus.out_ready = 1'b1;
      bus.procc_done = 1'b1;
      @(negedge clk);
      bus.procc_done = 1'b0;
      for (int k = 0; k < 8; k++) begin
         check("single_data", bus.out_data, exp_seq[k]);
         check("single_index", 32'(bus.out_index), 32'(k));
         check("single_last", 32'(bus.out_last), 32'(k == 7));
         @(negedge clk);
      end
      check("single_valid_after", 32'(bus.out_valid), 32'd0);
      check("single_count_after", 32'(bus.count), 32'd0);

      // Back-pressure: ready follows 1,0,0 with random captures
      for (int i = 0; i < 150; i++) begin
         bus.out_ready = (i % 3 == 0);
         bus.procc_done = ($urandom_range(0, 3) == 0);
         rand_lanes();
         @(negedge clk);
      end
      bus.procc_done = 1'b0;
      bus.out_ready = 1'b1;
      repeat (40) @(negedge clk);
      bus.clr_overflow = 1'b1;
      @(negedge clk);
      bus.clr_overflow = 1'b0;
      @(negedge clk);

      // Fill and overflow
      bus.out_ready = 1'b0;
      repeat (5) pulse_rand();
      check("fill_count", 32'(bus.count), 32'd4);
      check("fill_full", 32'(bus.full), 32'd1);
      check("fill_overflow", 32'(bus.overflow), 32'd1);
      bus.clr_overflow = 1'b1;
      @(negedge clk);
      bus.clr_overflow = 1'b0;
      check("clr_overflow", 32'(bus.overflow), 32'd0);
      bus.out_ready = 1'b1;
      repeat (32) @(negedge clk);
      check("drain_count", 32'(bus.count), 32'd0);
      check("drain_valid", 32'(bus.out_valid), 32'd0);

      // Capture on the same edge as the final-word pop of a full buffer
      bus.out_ready = 1'b0;
      repeat (4) pulse_rand();
      check("sim_full", 32'(bus.full), 32'd1);
      bus.out_ready = 1'b1;
      repeat (7) @(negedge clk);
      check("sim_index7", 32'(bus.out_index), 32'd7);
      rand_lanes();
      bus.procc_done = 1'b1;
      @(negedge clk);
      bus.procc_done = 1'b0;
      check("sim_count", 32'(bus.count), 32'd4);
      check("sim_overflow", 32'(bus.overflow), 32'd0);
      check("sim_index0", 32'(bus.out_index), 32'd0);
      repeat (40) @(negedge clk);
      check("sim_drained", 32'(bus.out_valid), 32'd0);

      // Reset mid-stream, then a fresh vector starts from index 0
      set_lanes(32'h50, 32'h60);
      bus.procc_done = 1'b1;
      @(negedge clk);
      bus.procc_done = 1'b0;
      repeat (4) @(negedge clk);
      #2 reset = 1'b0;
      #1 check_reset_outputs("midrst");
      @(negedge clk);
      reset = 1'b1;
      set_lanes(32'hA0, 32'hB0);
      bus.procc_done = 1'b1;
      @(negedge clk);
      bus.procc_done = 1'b0;
      check("post_rst_index", 32'(bus.out_index), 32'd0);
      check("post_rst_data", bus.out_data, 32'hA0);
      @(negedge clk);
      check("post_rst_data1", bus.out_data, 32'hB0);
      repeat (10) @(negedge clk);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         bus.procc_done = ($urandom_range(0, 2) == 0);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.clr_overflow = ($urandom_range(0, 15) == 0);
         rand_lanes();
         @(negedge clk);
      end
      bus.procc_done = 1'b0;
      bus.clr_overflow = 1'b0;
      bus.out_ready = 1'b1;
      repeat (40) @(negedge clk);
      check("final_valid", 32'(bus.out_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/simd_result_collector.md
# simd_result_collector

Downstream stage of the four-lane SIMD unit: captures the eight 32-bit lane outputs (result and extra_result of processors 0-3) each time the lanes report completion. Buffers up to DEPTH completed vectors. Streams them out one word per handshake over a valid/ready interface to the host/memory writeback path. It decouples the ALU completion rate from consumer back-pressure and flags any vector lost to overflow.

## Interface
- DEPTH, 4: number of buffered result vectors; power of two, ≥2.
- WORD_W, 32: lane word width.
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- procc_done  in  1  AND of the four lane done flags; level, synchronous to clk.
- res_p0..res_p3  in  WORD_W each  lane result words.
- ext_p0..ext_p3  in  WORD_W each  lane extra_result words.
- out_data  out  WORD_W  current stream word.
- out_index  out  3  word position in vector: 0=res_p0, 1=ext_p0, 2=res_p1, 3=ext_p1, 4=res_p2, 5=ext_p2, 6=res_p3, 7=ext_p3.
- out_valid  out  1  out_data valid.
- out_last  out  1  high with out_index==7.
- out_ready  in  1  consumer accepts word when out_valid && out_ready.
- full  out  1  count==DEPTH.
- count  out  clog2(DEPTH)+1  vectors buffered, including the one being streamed.
- overflow  out  1  sticky; a capture was dropped.
- clr_overflow  in  1  synchronous clear of overflow.

## Operation
- Capture event: procc_done high this cycle and low the previous cycle (internal registered copy; reset value 0). The eight words are written into the tail slot on that edge.
- Capture accepted if count<DEPTH, or if count==DEPTH and the head's final word (index 7) is popped in the same cycle. Otherwise the vector is dropped, overflow is set, and count is unchanged.
- FSM has two states:
  - IDLE: count==0, out_valid=0.
  - SEND: count≥1, out_valid=1, out_data = head slot word[word_ptr].
- On each pop, word_ptr increments. At word_ptr==7, the pop frees the head slot, the head pointer advances (wraps mod DEPTH), and word_ptr returns to 0.
- State transitions:
  - IDLE→SEND when a capture is accepted.
  - SEND→IDLE when the final word is popped, count becomes 0, and no capture is accepted in that cycle.
- count update: +1 on accepted capture, −1 on final-word pop. Both in the same cycle leaves count unchanged.
- clr_overflow has priority below a simultaneous overflow event: if a drop occurs in the same cycle, overflow stays 1.
- procc_done held high across many cycles produces exactly one capture. Capture requires a low cycle in between.
- Reset mid-stream discards all buffered vectors. The partially sent vector is not resumed.

## Timing
- Reset values: out_valid=0, out_last=0, out_index=0, out_data=0, full=0, count=0, overflow=0. Pointers and word_ptr are 0. State is IDLE.
- Latency: rising procc_done sampled at edge N with the buffer empty gives out_valid=1 with word 0 after edge N (visible in cycle N+1).
- Throughput: one word per cycle while out_ready=1. A vector takes 8 cycles. Back-to-back vectors have no bubble.
- While out_valid && !out_ready, out_data, out_index and out_last hold stable.
- out_valid never drops without a pop of the final word of the last buffered vector.
- Words are registered from storage. No combinational path from res_*/ext_* to out_data.

## Structure
- Shared package simd_pkg holds:
  - NUM_PROCC=4
  - WORDS_PER_VEC=2*NUM_PROCC
  - WORD_W default
  - FSM state enum {IDLE, SEND}
  - out_index encoding
- Sub-module simd_result_fifo: DEPTH×(8×WORD_W) storage, head/tail pointers, count, and full. It has a push port and a pop port. simd_result_collector adds edge detection, word_ptr, overflow, and the output handshake.

## Test plan
- Reset then idle: all outputs 0 and held for 20 cycles with procc_done=0.
- Single vector: res_p0..3=0x10..0x13, ext_p0..3=0x20..0x23, procc_done pulse, out_ready=1 → 8 words 0x10,0x20,0x11,0x21,0x12,0x22,0x13,0x23 on cycles N+1..N+8. out_last on the 8th word. Then count=0 and out_valid=0.
- Back-pressure: out_ready toggles 1,0,0,1,… → no word skipped or duplicated, and out_data is stable during stalls.
- Fill and overflow with DEPTH=4, out_ready=0: 5 capture pulses → count=4, full=1, overflow=1, and the 5th vector is absent. clr_overflow clears overflow. Draining yields 32 words in capture order.
- Simultaneous push and final pop at full: capture on the cycle the index-7 word pops → capture accepted, count stays 4, overflow stays 0.
- Reset mid-stream: assert reset after word 3 of a vector → outputs go to reset values immediately. After release, a new capture streams from index 0.
